// File: rtl/gpio_serial_loader.sv
// Fetches per-pad config words, shifts them MSB-first (pad NUM_PADS-1 first) into the GPIO chain, then strobes serial_load; start is ignored while busy.
// GPIO_LOADER_VERIFY_EN adds serial_data_in/cfg_mismatch and a second read-back pass that compares the chain tail against the re-shifted stream.
module gpio_serial_loader #(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 2,
  localparam int AW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  output logic [AW-1:0]       cfg_addr,
  input  logic [CFG_BITS-1:0] cfg_data,
`ifdef GPIO_LOADER_VERIFY_EN
  input  logic                serial_data_in,
  output logic                cfg_mismatch,
`endif
  output logic                busy,
  output logic                done,
  output logic                serial_clock,
  output logic                serial_load,
  output logic                serial_data_out
);

  localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam logic [AW-1:0] ADDR_LAST = AW'(NUM_PADS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CFG_BITS - 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV);
  localparam logic [DW-1:0] DIV_END   = DW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_LOAD,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                fetch2_q, fetch2_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DW-1:0]       div_q, div_d;
  logic [CFG_BITS-1:0] word_q, word_d;
  logic                sclk_q, sclk_d;
  logic                sdat_q, sdat_d;
  logic                sload_q, sload_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef GPIO_LOADER_VERIFY_EN
  logic                verify_q, verify_d;
  logic                mismatch_q, mismatch_d;
`endif

  always_comb begin
    state_d  = state_q;
    fetch2_d = fetch2_q;
    addr_d   = addr_q;
    bit_d    = bit_q;
    div_d    = div_q;
    word_d   = word_q;
`ifdef GPIO_LOADER_VERIFY_EN
    verify_d   = verify_q;
    mismatch_d = mismatch_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_FETCH;
          fetch2_d = 1'b0;
          addr_d   = ADDR_LAST;
`ifdef GPIO_LOADER_VERIFY_EN
          verify_d   = 1'b0;
          mismatch_d = 1'b0;
`endif
        end
      end
      // cfg_data lags cfg_addr by one cycle, so capture on the second cycle
      S_FETCH: begin
        if (!fetch2_q) begin
          fetch2_d = 1'b1;
        end else begin
          fetch2_d = 1'b0;
          state_d  = S_SHIFT;
          word_d   = cfg_data;
          bit_d    = BIT_LAST;
          div_d    = '0;
        end
      end
      S_SHIFT: begin
        if (div_q != DIV_END) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (bit_q != '0) begin
            bit_d  = bit_q - 1'b1;
            word_d = word_q << 1;
          end else if (addr_q != '0) begin
            addr_d  = addr_q - 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (div_q != DIV_END) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
`ifdef GPIO_LOADER_VERIFY_EN
          if (!verify_q) begin
            verify_d = 1'b1;
            addr_d   = ADDR_LAST;
            state_d  = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
`else
          state_d = S_DONE;
`endif
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from next-state values so the chain sees glitch-free levels
    sclk_d  = (state_d == S_SHIFT) && (div_d >= DIV_HALF);
    sload_d = (state_d == S_LOAD) && (div_d < DIV_HALF);
    sdat_d  = ((state_d == S_SHIFT) && (div_d == '0)) ? word_d[CFG_BITS-1] : sdat_q;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);

`ifdef GPIO_LOADER_VERIFY_EN
    // Tail bit is sampled before the chain shifts on this rising edge
    if (verify_q && (state_q == S_SHIFT) && sclk_d && !sclk_q && (serial_data_in != sdat_q))
      mismatch_d = 1'b1;
`endif
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      fetch2_q <= 1'b0;
      addr_q   <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      word_q   <= '0;
      sclk_q   <= 1'b0;
      sdat_q   <= 1'b0;
      sload_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef GPIO_LOADER_VERIFY_EN
      verify_q   <= 1'b0;
      mismatch_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      fetch2_q <= fetch2_d;
      addr_q   <= addr_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      word_q   <= word_d;
      sclk_q   <= sclk_d;
      sdat_q   <= sdat_d;
      sload_q  <= sload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef GPIO_LOADER_VERIFY_EN
      verify_q   <= verify_d;
      mismatch_q <= mismatch_d;
`endif
    end
  end

  assign cfg_addr        = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign serial_clock    = sclk_q;
  assign serial_load     = sload_q;
  assign serial_data_out = sdat_q;
`ifdef GPIO_LOADER_VERIFY_EN
  assign cfg_mismatch    = mismatch_q;
`endif

endmodule
